pir_motion_ctrl: RTL

PIR_MOTION_CTRL -- requirements
Module: pir_motion_ctrl

---
 rtl/pir_pkg.sv | 21 ++
 rtl/pir_debounce.sv | 36 +++
 rtl/pir_motion_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pir_pkg.sv
// Shared types for the PIR motion controller: FSM state encoding and a counter-width helper.
package pir_pkg;

    localparam logic [1:0] ENC_WARMUP = 2'd0;
    localparam logic [1:0] ENC_IDLE   = 2'd1;
    localparam logic [1:0] ENC_ACTIVE = 2'd2;
    localparam logic [1:0] ENC_HOLD   = 2'd3;

    typedef enum logic [1:0] {
        ST_WARMUP = ENC_WARMUP,
        ST_IDLE   = ENC_IDLE,
        ST_ACTIVE = ENC_ACTIVE,
        ST_HOLD   = ENC_HOLD
    } pir_state_t;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pir_debounce.sv
// One PIR channel: 2-flop synchroniser followed by a DEB_LEN-sample debounce window.
module pir_debounce
    import pir_pkg::*;
#(
    parameter int DEB_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pir,
    output logic motion
);

    logic               sync1;
    logic               sync2;
    logic [DEB_LEN-1:0] shreg;

    // Flag only moves on a full window of agreeing samples; mixed windows hold it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            shreg  <= '0;
            motion <= 1'b0;
        end else begin
            sync1 <= pir;
            sync2 <= sync1;
            shreg <= {shreg[DEB_LEN-2:0], sync2};
            if (&shreg) begin
                motion <= 1'b1;
            end else if (~|shreg) begin
                motion <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pir_motion_ctrl.sv
// PIR motion controller: per-channel debounce, warm-up/idle/active/hold sequencing,
// blinking indicator LED and a saturating event counter.
//
// state  | meaning
// WARMUP | sensors settling after reset, motion ignored
// IDLE   | no motion, LED off, waiting for an event
// ACTIVE | motion present, LED blinking
// HOLD   | motion gone, waiting HOLD_CYC cycles before returning to IDLE
module pir_motion_ctrl
    import pir_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DEB_LEN    = 4,
    parameter int WARMUP_CYC = 32000000,
    parameter int HOLD_CYC   = 32000000,
    parameter int BLINK_HALF = 16000000,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  pir_in,
    input  logic [N_CH-1:0]  ch_enable,
    input  logic             clear_count,
    output logic [N_CH-1:0]  motion_vec,
    output logic             motion_any,
    output logic             led,
    output logic             event_pulse,
    output logic [CNT_W-1:0] event_count,
    output logic [1:0]       state
);

    localparam int WARM_W  = cnt_width(WARMUP_CYC);
    localparam int HOLD_W  = cnt_width(HOLD_CYC);
    localparam int BLINK_W = cnt_width(BLINK_HALF);

    localparam logic [WARM_W-1:0]  WARM_LAST  = WARM_W'(WARMUP_CYC - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    pir_state_t         cur;
    pir_state_t         nxt;
    logic               m;
    logic               evt;
    logic [WARM_W-1:0]  warm_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [BLINK_W-1:0] blink_cnt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pir_debounce #(
            .DEB_LEN (DEB_LEN)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .pir    (pir_in[i]),
            .motion (motion_vec[i])
        );
    end

    assign m     = |(motion_vec & ch_enable);
    assign state = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= ST_WARMUP;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        evt = 1'b0;
        case (cur)
            ST_WARMUP: begin
                if (warm_cnt == WARM_LAST) begin
                    nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (m) begin
                    nxt = ST_ACTIVE;
                    evt = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!m) begin
                    nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Returning motion beats an expiring hold timer.
                if (m) begin
                    nxt = ST_ACTIVE;
                end else if (hold_cnt == HOLD_LAST) begin
                    nxt = ST_IDLE;
                end
            end
            default: nxt = ST_WARMUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            warm_cnt <= (cur == ST_WARMUP && warm_cnt != WARM_LAST) ? warm_cnt + WARM_W'(1) : '0;
            hold_cnt <= (cur == ST_HOLD && nxt == ST_HOLD) ? hold_cnt + HOLD_W'(1) : '0;
        end
    end

    // Blink phase runs across ACTIVE<->HOLD; only a new event or leaving to IDLE restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            led       <= 1'b0;
            blink_cnt <= '0;
        end else if (evt) begin
            led       <= 1'b1;
            blink_cnt <= '0;
        end else if (nxt == ST_ACTIVE || nxt == ST_HOLD) begin
            if (blink_cnt == BLINK_LAST) begin
                led       <= ~led;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end else begin
            led       <= 1'b0;
            blink_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            motion_any  <= 1'b0;
            event_pulse <= 1'b0;
            event_count <= '0;
        end else begin
            motion_any  <= m;
            event_pulse <= evt;
            if (clear_count) begin
                event_count <= CNT_W'(evt);
            end else if (evt && event_count != CNT_MAX) begin
                event_count <= event_count + CNT_W'(1);
            end
        end
    end

endmodule
